// File: rtl/audio_sample_memory_if.sv
// rtl/audio_sample_memory_if.sv - read request, loader and status signals of the audio sample memory
interface audio_sample_memory_if;
  logic [31:0] mem_addr;
  logic        mem_cs;
  logic [31:0] mem_dout;
  logic        mem_ack;
  logic        ld_wr;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        busy;
  logic        err_ovf;
  logic        err_clr;

  modport master (
    output mem_addr, mem_cs, ld_wr, ld_addr, ld_data, err_clr,
    input  mem_dout, mem_ack, busy, err_ovf
  );

  modport slave (
    input  mem_addr, mem_cs, ld_wr, ld_addr, ld_data, err_clr,
    output mem_dout, mem_ack, busy, err_ovf
  );
endinterface

// File: rtl/audio_sample_memory.sv
// rtl/audio_sample_memory.sv - wait-stated sample RAM with one pending request slot and loader port
// Optional bounds checking of read/load addresses: define AUDIO_MEM_BOUNDS_EN.
module audio_sample_memory #(
  parameter int ADDR_BITS = 12,
  parameter int WAIT      = 2
) (
  input  logic                  clk,
  input  logic                  res,
  audio_sample_memory_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_ACK} state_t;

  localparam state_t      FIRST     = (WAIT > 0) ? S_WAIT : S_READ;
  localparam logic [3:0]  WAIT_INIT = 4'((WAIT > 0) ? WAIT - 1 : 0);
  localparam logic [31:0] SILENCE   = 32'h8080_8080;

  logic [31:0]          ram [2**ADDR_BITS];
  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] cur_addr, pend_addr, req_idx;
  logic                 cur_oob, pend_oob, pend_v, req_oob, ld_ok;
  logic [3:0]           wait_cnt;
  logic [31:0]          rdata;
  logic                 err_ovf_q;
  logic                 load_cur_bus, load_cur_pend, accept_pend, drop;

  assign req_idx = bus.mem_addr[ADDR_BITS-1:0];

`ifdef AUDIO_MEM_BOUNDS_EN
  assign req_oob = |bus.mem_addr[31:ADDR_BITS];
  assign ld_ok   = ~|bus.ld_addr[31:ADDR_BITS];
`else
  logic unused_hi;
  assign req_oob   = 1'b0;
  assign ld_ok     = 1'b1;
  assign unused_hi = ^{bus.mem_addr[31:ADDR_BITS], bus.ld_addr[31:ADDR_BITS]};
`endif

  // The loader always owns the RAM; a READ stalls rather than contend for it.
  always_ff @(posedge clk) begin
    if (!res && bus.ld_wr && ld_ok)
      ram[bus.ld_addr[ADDR_BITS-1:0]] <= bus.ld_data;
  end

  always_comb begin
    state_nxt     = state;
    load_cur_bus  = 1'b0;
    load_cur_pend = 1'b0;
    accept_pend   = 1'b0;
    drop          = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.mem_cs) begin
          load_cur_bus = 1'b1;
          state_nxt    = FIRST;
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) state_nxt = S_READ;
        accept_pend = bus.mem_cs && !pend_v;
        drop        = bus.mem_cs && pend_v;
      end
      S_READ: begin
        if (!bus.ld_wr) state_nxt = S_ACK;
        accept_pend = bus.mem_cs && !pend_v;
        drop        = bus.mem_cs && pend_v;
      end
      S_ACK: begin
        // The pending slot frees up this cycle, so a new strobe is never dropped here.
        if (pend_v) begin
          load_cur_pend = 1'b1;
          accept_pend   = bus.mem_cs;
          state_nxt     = FIRST;
        end else if (bus.mem_cs) begin
          load_cur_bus  = 1'b1;
          state_nxt     = FIRST;
        end else begin
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      cur_oob   <= 1'b0;
      pend_v    <= 1'b0;
      pend_addr <= '0;
      pend_oob  <= 1'b0;
      wait_cnt  <= '0;
      rdata     <= '0;
      err_ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_cur_bus) begin
        cur_addr <= req_idx;
        cur_oob  <= req_oob;
      end else if (load_cur_pend) begin
        cur_addr <= pend_addr;
        cur_oob  <= pend_oob;
      end
      if (load_cur_pend) pend_v <= 1'b0;
      if (accept_pend) begin
        pend_v    <= 1'b1;
        pend_addr <= req_idx;
        pend_oob  <= req_oob;
      end
      if (state_nxt == S_WAIT && state != S_WAIT)
        wait_cnt <= WAIT_INIT;
      else if (state == S_WAIT && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
      if (state == S_READ && !bus.ld_wr)
        rdata <= cur_oob ? SILENCE : ram[cur_addr];
      if (drop)
        err_ovf_q <= 1'b1;
      else if (bus.err_clr)
        err_ovf_q <= 1'b0;
    end
  end

  assign bus.mem_ack  = (state == S_ACK);
  assign bus.mem_dout = (state == S_ACK) ? rdata : 32'h0;
  assign bus.busy     = (state != S_IDLE) || pend_v;
  assign bus.err_ovf  = err_ovf_q;

endmodule

// File: tb/tb_audio_sample_memory.sv
// tb/tb_audio_sample_memory.sv - scoreboard bench for audio_sample_memory
module tb_audio_sample_memory;
  localparam int W  = 2;
  localparam int AB = 12;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int          at;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  audio_sample_memory_if bus();

  audio_sample_memory #(.ADDR_BITS(AB), .WAIT(W)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ack must match the oldest expectation in data and cycle.
  always @(negedge clk) begin
    if (bus.mem_ack) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack cycle=%0d dout=%h", cyc, bus.mem_dout);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.at != cyc || e.data != bus.mem_dout) begin
          errors++;
          $display("FAIL ack got cycle=%0d dout=%h, want cycle=%0d dout=%h",
                   cyc, bus.mem_dout, e.at, e.data);
        end
      end
    end else if (bus.mem_dout != 32'h0) begin
      checks++;
      errors++;
      $display("FAIL dout_idle got %h want 00000000 cycle=%0d", bus.mem_dout, cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    bus.ld_wr = 1'b1; bus.ld_addr = a; bus.ld_data = d;
    tick();
    bus.ld_wr = 1'b0;
  endtask

  task automatic strobe(input logic [31:0] a);
    bus.mem_cs = 1'b1; bus.mem_addr = a;
  endtask

  task automatic expect_ack(input int at, input logic [31:0] d);
    exp_t e;
    e.at = at; e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.busy || sb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout busy=%0b pending=%0d", bus.busy, sb.size());
    end
    tick();
  endtask

  initial begin
    int c;
    bus.mem_cs = 1'b0; bus.mem_addr = '0; bus.ld_wr = 1'b0;
    bus.ld_addr = '0; bus.ld_data = '0; bus.err_clr = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_busy", {31'b0, bus.busy}, 32'h0);
    check("reset_err", {31'b0, bus.err_ovf}, 32'h0);
    check("reset_ack", {31'b0, bus.mem_ack}, 32'h0);
    check("reset_dout", bus.mem_dout, 32'h0);
    tick();
    res = 1'b0;
    tick();

    load(32'h10, 32'h1122_3344);
    load(32'h1, 32'h0000_00a1);
    load(32'h2, 32'h0000_00a2);
    load(32'h3, 32'h0000_00a3);
    load(32'h0, 32'hcafe_f00d);
    load(32'h5, 32'h5555_5555);
    load(32'h20, 32'h5566_7788);

    // basic latency N+WAIT+2
    c = cyc; strobe(32'h10); expect_ack(c + W + 2, 32'h1122_3344);
    tick(); bus.mem_cs = 1'b0;
    wait_idle();

    // three strobes: third dropped
    c = cyc; strobe(32'h1); expect_ack(c + 4, 32'ha1);
    tick(); strobe(32'h2); expect_ack(c + 8, 32'ha2);
    tick(); strobe(32'h3);
    tick(); bus.mem_cs = 1'b0;
    wait_idle();
    @(negedge clk);
    check("ovf_set", {31'b0, bus.err_ovf}, 32'h1);
    tick();
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
    @(negedge clk);
    check("ovf_clr", {31'b0, bus.err_ovf}, 32'h0);
    tick();

    // loader holds RAM during READ: one extra cycle
    c = cyc; strobe(32'h20); expect_ack(c + W + 3, 32'h5566_7788);
    tick(); bus.mem_cs = 1'b0;
    tick(); tick();
    load(32'h30, 32'h0000_0099);
    wait_idle();
    c = cyc; strobe(32'h30); expect_ack(c + 4, 32'h99);
    tick(); bus.mem_cs = 1'b0;
    wait_idle();

    // strobe during ACK with pend empty, then with pend full
    c = cyc; strobe(32'h10); expect_ack(c + 4, 32'h1122_3344);
    tick(); bus.mem_cs = 1'b0;
    tick(); tick(); tick();
    strobe(32'h20); expect_ack(c + 8, 32'h5566_7788);
    tick(); bus.mem_cs = 1'b0;
    wait_idle();
    c = cyc; strobe(32'h1); expect_ack(c + 4, 32'ha1);
    tick(); strobe(32'h2); expect_ack(c + 8, 32'ha2);
    tick(); bus.mem_cs = 1'b0;
    tick(); tick();
    strobe(32'h3); expect_ack(c + 12, 32'ha3);
    tick(); bus.mem_cs = 1'b0;
    wait_idle();
    @(negedge clk);
    check("ack_accept_no_ovf", {31'b0, bus.err_ovf}, 32'h0);
    tick();

    // out-of-range addresses
    load(32'h1005, 32'h0000_dead);
`ifdef AUDIO_MEM_BOUNDS_EN
    c = cyc; strobe(32'h1000); expect_ack(c + 4, 32'h8080_8080);
    tick(); bus.mem_cs = 1'b0; wait_idle();
    c = cyc; strobe(32'h5); expect_ack(c + 4, 32'h5555_5555);
`else
    c = cyc; strobe(32'h1000); expect_ack(c + 4, 32'hcafe_f00d);
    tick(); bus.mem_cs = 1'b0; wait_idle();
    c = cyc; strobe(32'h5); expect_ack(c + 4, 32'h0000_dead);
`endif
    tick(); bus.mem_cs = 1'b0;
    wait_idle();

    // reset mid-request aborts everything
    strobe(32'h1);
    tick(); strobe(32'h2);
    tick(); strobe(32'h3);
    tick(); bus.mem_cs = 1'b0; res = 1'b1;
    bus.ld_wr = 1'b1; bus.ld_addr = 32'h10; bus.ld_data = 32'hffff_ffff;
    @(negedge clk);
    check("pre_reset_ovf", {31'b0, bus.err_ovf}, 32'h1);
    check("pre_reset_busy", {31'b0, bus.busy}, 32'h1);
    tick(); res = 1'b0; bus.ld_wr = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    check("post_reset_busy", {31'b0, bus.busy}, 32'h0);
    check("post_reset_ovf", {31'b0, bus.err_ovf}, 32'h0);
    tick();
    c = cyc; strobe(32'h10); expect_ack(c + 4, 32'h1122_3344);
    tick(); bus.mem_cs = 1'b0;
    wait_idle();

    check("scoreboard_empty", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/audio_sample_memory.md
AUDIO_SAMPLE_MEMORY -- requirements
Module: audio_sample_memory

Interface
REQ-001 Parameter ADDR_BITS, default 12, sets word-address width of the internal sample RAM (depth 2^ADDR_BITS words of 32 bits).
REQ-002 Parameter WAIT, default 2, sets extra wait cycles per read; legal range 0-15.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 res  input  1  reset, synchronous, active-high.
REQ-005 mem_addr  input  32  word address of the read request; valid when mem_cs is high.
REQ-006 mem_cs  input  1  single-cycle read request strobe from the audio controller.
REQ-007 mem_dout  output  32  read data; valid only while mem_ack is high.
REQ-008 mem_ack  output  1  single-cycle read-complete strobe.
REQ-009 ld_wr  input  1  loader write strobe, one word per cycle.
REQ-010 ld_addr  input  32  loader word address.
REQ-011 ld_data  input  32  loader write data (four packed 8-bit unsigned samples).
REQ-012 busy  output  1  high whenever the state is not IDLE or the pending slot is occupied.
REQ-013 err_ovf  output  1  sticky flag: a request was dropped.
REQ-014 err_clr  input  1  clears err_ovf.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, READ, ACK; one active request register (cur) and one pending slot (pend).
REQ-016 IDLE with mem_cs high: latch mem_addr into cur; go to WAIT if WAIT>0, else READ.
REQ-017 WAIT: count WAIT cycles, then go to READ.
REQ-018 READ: present cur address to the synchronous RAM; go to ACK next cycle, except when ld_wr is high in the same cycle (loader has RAM priority), in which case READ repeats.
REQ-019 ACK: mem_ack=1 for exactly one cycle, with mem_dout = RAM word; mem_dout returns to 0 when mem_ack is low.
REQ-020 Uncontended latency: mem_cs sampled in cycle N -> mem_ack high in cycle N+WAIT+2.
REQ-021 mem_cs while the state is not IDLE: store the address in pend if pend is empty; if pend is full, drop the request and set err_ovf.
REQ-022 Leaving ACK: if pend is valid, move pend to cur and enter WAIT/READ (same rule as REQ-016), else enter IDLE; mem_cs in that same ACK cycle is accepted into pend, because pend is freed that cycle.
REQ-023 ld_wr SHALL write ld_data to ld_addr[ADDR_BITS-1:0] in the same cycle regardless of FSM state; a read of the same address in a later READ cycle returns the new data.
REQ-024 err_ovf set has priority over err_clr in the same cycle.
REQ-025 Requests are served strictly in arrival order; no request produces more than one mem_ack.

Reset
REQ-026 res high SHALL force: state IDLE, mem_ack 0, mem_dout 0, pend empty, cur 0, wait counter 0, err_ovf 0, busy 0, on the next edge.
REQ-027 Reset mid-request SHALL abort the request; no mem_ack is issued for it afterwards.
REQ-028 RAM contents are not reset; ld_wr is ignored while res is high.

Configuration
REQ-029 Macro AUDIO_MEM_BOUNDS_EN defined: a read with mem_addr >= 2^ADDR_BITS completes with normal latency and mem_dout = 32'h80808080 (four silent samples); a loader write with ld_addr >= 2^ADDR_BITS is discarded.
REQ-030 AUDIO_MEM_BOUNDS_EN undefined: upper address bits are ignored; reads and writes wrap modulo 2^ADDR_BITS.

Verification
REQ-031 Load 0x00000010 <- 32'h11223344; mem_cs with addr 0x10 in cycle 100 (WAIT=2) -> mem_ack=1 and mem_dout=32'h11223344 in cycle 104 only.
REQ-032 Three mem_cs strobes at cycles 0, 1, 2 with addrs 0x1, 0x2, 0x3 -> acks for 0x1 and 0x2 in order; 0x3 dropped; err_ovf=1 until err_clr.
REQ-033 ld_wr held high during the READ cycle -> mem_ack delayed to cycle N+WAIT+3; data correct.
REQ-034 res pulsed in WAIT -> no mem_ack in the next 20 cycles; busy=0, err_ovf=0.
REQ-035 Read addr 0x00001000 with ADDR_BITS=12 -> with AUDIO_MEM_BOUNDS_EN: mem_dout=32'h80808080; without it: data of word 0x000.
REQ-036 mem_cs coincident with ACK, pend empty -> accepted; ack follows WAIT+2 cycles after the ACK cycle; err_ovf stays 0.
